// File: rtl/lif_neuron_core.sv
// lif_neuron_core: leaky integrate-and-fire neuron over N_IN weighted inputs.
// Ports: clk, rst (sync, active-high), ena (freeze when low);
//   x_flat/in_valid/in_ready input handshake; w_we/w_addr/w_data weight bus;
//   threshold, leak_shift runtime knobs; out_valid, spike, membrane,
//   spike_count results.
// Build option: NEURON_LEAK_EN enables the v >>> leak_shift leak term.
module lif_neuron_core #(
  parameter int N_IN          = 2,
  parameter int X_W           = 4,
  parameter int W_W           = 4,
  parameter int ACC_W         = 12,
  parameter int REFRAC_CYCLES = 3,
  localparam int A_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [N_IN*X_W-1:0]     x_flat,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    w_we,
  input  logic [A_W-1:0]          w_addr,
  input  logic [W_W-1:0]          w_data,
  input  logic signed [ACC_W-1:0] threshold,
  input  logic [3:0]              leak_shift,
  output logic                    out_valid,
  output logic                    spike,
  output logic signed [ACC_W-1:0] membrane,
  output logic [7:0]              spike_count
);

  localparam int P_W = X_W + W_W + 1;
  localparam int R_W = $clog2(REFRAC_CYCLES + 2);
  localparam logic [A_W-1:0] LAST = A_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] V_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] V_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EVAL,
    REFRAC
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_IN*X_W-1:0]     x_q;
  logic signed [W_W-1:0]   w_q [N_IN];
  logic [A_W-1:0]          idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] mem_q;
  logic [R_W-1:0]          rcnt_q;
  logic [7:0]              cnt_q;
  logic                    ov_q;
  logic                    spk_q;

  assign in_ready    = (state_q == IDLE) && ena;
  assign out_valid   = ov_q;
  assign spike       = spk_q;
  assign membrane    = mem_q;
  assign spike_count = cnt_q;

  // Multiply-accumulate for the current index.
  logic [X_W-1:0]          x_cur;
  logic signed [W_W-1:0]   w_cur;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_sat;

  always_comb begin
    x_cur = x_q[idx_q*X_W +: X_W];
    w_cur = w_q[idx_q];
    prod  = $signed({{(P_W-X_W){1'b0}}, x_cur}) *
            $signed({{(P_W-W_W){w_cur[W_W-1]}}, w_cur});
    acc_sum = {acc_q[ACC_W-1], acc_q} +
              {{(ACC_W+1-P_W){prod[P_W-1]}}, prod};
    // One guard bit: overflow when the top two bits disagree.
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_sat = acc_sum[ACC_W] ? V_MIN : V_MAX;
    end else begin
      acc_sat = acc_sum[ACC_W-1:0];
    end
  end

  // Leak term.
  logic signed [ACC_W-1:0] leak;

`ifdef NEURON_LEAK_EN
  always_comb begin
    leak = '0;
    // Separate statement keeps the shift arithmetic (signed context).
    if (leak_shift != 4'd0) begin
      leak = mem_q >>> leak_shift;
    end
  end
`else
  logic unused_leak;
  assign unused_leak = ^leak_shift;
  assign leak        = '0;
`endif

  // Membrane update candidate and firing decision.
  logic signed [ACC_W+1:0] v_sum;
  logic signed [ACC_W-1:0] v_sat;
  logic                    fire;

  always_comb begin
    v_sum = {{2{mem_q[ACC_W-1]}}, mem_q} -
            {{2{leak[ACC_W-1]}}, leak} +
            {{2{acc_q[ACC_W-1]}}, acc_q};
    // In range only if the three top bits are identical.
    if ((&v_sum[ACC_W+1:ACC_W-1]) ||
        (~|v_sum[ACC_W+1:ACC_W-1])) begin
      v_sat = v_sum[ACC_W-1:0];
    end else begin
      v_sat = v_sum[ACC_W+1] ? V_MIN : V_MAX;
    end
    fire = (v_sat >= threshold);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        if (idx_q == LAST) state_d = EVAL;
      end
      EVAL: begin
        if (fire && (REFRAC_CYCLES > 0)) state_d = REFRAC;
        else state_d = IDLE;
      end
      REFRAC: begin
        if (rcnt_q <= R_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      mem_q  <= '0;
      rcnt_q <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
      spk_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= W_W'(1);
      end
    end else if (ena) begin
      ov_q  <= 1'b0;
      spk_q <= 1'b0;
      if (w_we && (int'(w_addr) < N_IN)) begin
        w_q[w_addr] <= w_data;
      end
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q   <= x_flat;
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_sat;
          idx_q <= idx_q + 1'b1;
        end
        EVAL: begin
          ov_q <= 1'b1;
          if (fire) begin
            spk_q  <= 1'b1;
            mem_q  <= '0;
            cnt_q  <= cnt_q + 8'd1;
            rcnt_q <= R_W'(REFRAC_CYCLES);
          end else begin
            mem_q <= v_sat;
          end
        end
        REFRAC: begin
          rcnt_q <= rcnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb_lif_neuron_core: directed and random stimulus for lif_neuron_core,
// compared each cycle against a transaction-level neuron model.
module tb_lif_neuron_core;

  localparam int N_IN  = 2;
  localparam int X_W   = 4;
  localparam int W_W   = 4;
  localparam int ACC_W = 12;
  localparam int RC    = 3;
  localparam int VMAX  = (1 << (ACC_W-1)) - 1;
  localparam int VMIN  = -(1 << (ACC_W-1));

  logic clk = 1'b0;
  logic rst, ena, in_valid, in_ready, w_we;
  logic out_valid, spike;
  logic [N_IN*X_W-1:0] x_flat;
  logic [0:0] w_addr;
  logic [W_W-1:0] w_data;
  logic signed [ACC_W-1:0] threshold;
  logic signed [ACC_W-1:0] membrane;
  logic [3:0] leak_shift;
  logic [7:0] spike_count;
  logic [X_W-1:0] dx [N_IN];

  always #5 clk = ~clk;

  always_comb begin
    x_flat = '0;
    for (int i = 0; i < N_IN; i++) x_flat[i*X_W +: X_W] = dx[i];
  end

  lif_neuron_core #(
    .N_IN(N_IN), .X_W(X_W), .W_W(W_W),
    .ACC_W(ACC_W), .REFRAC_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .x_flat(x_flat), .in_valid(in_valid), .in_ready(in_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .threshold(threshold), .leak_shift(leak_shift),
    .out_valid(out_valid), .spike(spike),
    .membrane(membrane), .spike_count(spike_count)
  );

  // Model: one vector in flight, timed by edges since acceptance.
  int m_w [N_IN];
  int m_x [N_IN];
  int m_v, m_acc, m_cnt, m_step, m_wait;
  bit m_active, m_ov, m_sp;
  int checks = 0;
  int errors = 0;
  bit last_ready;

  function automatic int sat(input int v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_IN; i++) m_w[i] = 1;
    m_v = 0; m_acc = 0; m_cnt = 0;
    m_step = 0; m_wait = 0;
    m_active = 0; m_ov = 0; m_sp = 0;
  endfunction

  function automatic bit m_ready();
    return !m_active && (m_wait == 0) && (ena == 1'b1);
  endfunction

  function automatic void model_step();
    int vn, lk;
    if (rst) begin
      model_reset();
      return;
    end
    if (!ena) return;
    m_ov = 0;
    m_sp = 0;
    if (m_active) begin
      m_step++;
      if (m_step <= N_IN) begin
        m_acc = sat(m_acc + m_w[m_step-1] * m_x[m_step-1]);
      end else begin
        lk = 0;
`ifdef NEURON_LEAK_EN
        if (leak_shift != 4'd0) lk = m_v >>> leak_shift;
`endif
        vn = sat(m_v - lk + m_acc);
        m_ov = 1;
        m_active = 0;
        if (vn >= int'($signed(threshold))) begin
          m_sp = 1;
          m_v = 0;
          m_cnt = (m_cnt + 1) % 256;
          m_wait = RC;
        end else begin
          m_v = vn;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (in_valid) begin
      m_active = 1;
      m_step = 0;
      m_acc = 0;
      for (int i = 0; i < N_IN; i++) m_x[i] = int'(dx[i]);
    end
    if (w_we && (int'(w_addr) < N_IN))
      m_w[int'(w_addr)] = int'($signed(w_data));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are set at a negedge; this covers the following posedge.
  task automatic tick();
    #1;
    last_ready = in_ready;
    chk("in_ready", int'(in_ready), int'(m_ready()));
    model_step();
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("spike", int'(spike), int'(m_sp));
    chk("membrane", int'($signed(membrane)), m_v);
    chk("spike_count", int'(spike_count), m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wrtw(input int a, input int d);
    w_we = 1'b1;
    w_addr = a[0:0];
    w_data = d[W_W-1:0];
    tick();
    w_we = 1'b0;
  endtask

  task automatic send(input int a, input int b);
    bit ok;
    ok = 0;
    dx[0] = a[X_W-1:0];
    dx[1] = b[X_W-1:0];
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_ready) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    repeat (N_IN + 1) tick();
    chk("ov_latency", int'(out_valid), 1);
  endtask

  int exp_leak [6];
  int acc_t [$];
  int ov_t [$];

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    threshold = 12'sd8; leak_shift = 4'd0;
    for (int i = 0; i < N_IN; i++) dx[i] = '0;
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_membrane", int'($signed(membrane)), 0);
    chk("rst_count", int'(spike_count), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);

    // Integrate to threshold, then refractory
    threshold = 12'sd8;
    leak_shift = 4'd0;
    send(1, 1);
    chk("int_v1", int'($signed(membrane)), 2);
    send(1, 1);
    chk("int_v2", int'($signed(membrane)), 4);
    send(1, 1);
    chk("int_v3", int'($signed(membrane)), 6);
    chk("int_nospike", int'(spike), 0);
    send(1, 1);
    chk("int_spike", int'(spike), 1);
    chk("int_v4", int'($signed(membrane)), 0);
    chk("int_count", int'(spike_count), 1);
    chk("refrac_r0", int'(in_ready), 0);
    tick();
    chk("refrac_r1", int'(in_ready), 0);
    tick();
    chk("refrac_r2", int'(in_ready), 0);
    tick();
    chk("refrac_r3", int'(in_ready), 1);

    // Leak
`ifdef NEURON_LEAK_EN
    exp_leak = '{8, 12, 14, 15, 16, 16};
`else
    exp_leak = '{8, 16, 24, 32, 40, 48};
`endif
    do_reset();
    threshold = 12'sd100;
    leak_shift = 4'd1;
    for (int i = 0; i < 6; i++) begin
      send(4, 4);
      chk("leak_v", int'($signed(membrane)), exp_leak[i]);
      chk("leak_nospike", int'(spike), 0);
    end
    leak_shift = 4'd0;

    // Signed weights
    do_reset();
    wrtw(0, -8);
    wrtw(1, 7);
    threshold = 12'sd8;
    send(15, 15);
    chk("sw_v", int'($signed(membrane)), -15);
    chk("sw_spike", int'(spike), 0);
    tick();
    chk("sw_ov_pulse", int'(out_valid), 0);

    // Saturation
    do_reset();
    wrtw(0, 7);
    wrtw(1, 7);
    threshold = 12'sd2047;
    for (int i = 0; i < 9; i++) send(15, 15);
    chk("sat_v9", int'($signed(membrane)), 1890);
    chk("sat_nospike", int'(spike_count), 0);
    send(15, 15);
    chk("sat_spike", int'(spike), 1);
    chk("sat_v10", int'($signed(membrane)), 0);
    chk("sat_count", int'(spike_count), 1);

    // Backpressure and latency
    do_reset();
    threshold = 12'sd1000;
    dx[0] = 4'd1;
    dx[1] = 4'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_ready) acc_t.push_back(k);
      if (out_valid) ov_t.push_back(k);
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc_t.size(), 5);
    chk("bp_outs", ov_t.size(), 5);
    for (int i = 1; i < acc_t.size(); i++)
      chk("bp_period", acc_t[i] - acc_t[i-1], N_IN + 2);
    for (int i = 0; i < acc_t.size() && i < ov_t.size(); i++)
      chk("bp_latency", ov_t[i] - acc_t[i], N_IN + 1);
    repeat (4) tick();

    // Reset in the first ACCUM cycle
    do_reset();
    wrtw(0, 5);
    dx[0] = 4'd2;
    dx[1] = 4'd3;
    in_valid = 1'b1;
    tick();
    chk("mid_accepted", int'(last_ready), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ov", int'(out_valid), 0);
    chk("mid_membrane", int'($signed(membrane)), 0);
    chk("mid_ready", int'(in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_ov", int'(out_valid), 0);
    end
    send(2, 3);
    chk("mid_weights", int'($signed(membrane)), 5);

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int t;
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 9) != 0);
      in_valid = $urandom_range(0, 1) != 0;
      for (int i = 0; i < N_IN; i++)
        dx[i] = X_W'($urandom_range(0, 15));
      w_we = ($urandom_range(0, 7) == 0);
      w_addr = 1'($urandom_range(0, 1));
      w_data = W_W'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) begin
        t = int'($urandom_range(0, 900)) - 300;
        threshold = t[ACC_W-1:0];
      end
      if ($urandom_range(0, 31) == 0)
        leak_shift = 4'($urandom_range(0, 4));
      tick();
    end
    rst = 1'b0;
    ena = 1'b1;
    in_valid = 1'b0;
    w_we = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
